// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch front end.
// Holds the NOP encoding, the front-end state encodings and the
// primary opcode constants used across the pipeline.
package cpu_defs;

  // sll $0,$0,0 encodes as all zeros and is the pipeline bubble.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Front-end state as seen on fe_state.
  typedef enum logic [1:0] {
    FE_RUN   = 2'd0,
    FE_STALL = 2'd1,
    FE_FLUSH = 2'd2,
    FE_FILL  = 2'd3
  } fe_state_t;

  // Primary opcode field values (instruction bits 31:26).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Extract the primary opcode field of an instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset, loads RESET_VAL
//   load    - capture d on the next edge
//   clear   - load CLEAR_VAL on the next edge; wins over load
//   d       - data in
//   q       - registered data out
module pipe_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter logic [WIDTH-1:0]  CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear has priority so a flush can never be overridden by a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= CLEAR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pipe_front.sv
// Instruction fetch front end: PC, IF/ID and ID/EX registers.
// Ports:
//   clk, reset_n            - clock and async active-low reset
//   regIF_en, regID_en      - PC advance and IF/ID load enables
//   nopMux                  - inject a bubble into ID/EX
//   redirect, redirect_pc   - taken branch/jump from EX and its target
//   imem_data / imem_addr   - instruction memory interface (same-cycle read)
//   instruction_ID, pc_plus4_ID, valid_ID - IF/ID contents
//   instruction_EX, valid_EX              - ID/EX contents
//   fe_state     - RUN/STALL/FLUSH/FILL
//   stall_count  - saturating count of cycles where IF/ID held
//   protocol_err - sticky flag for PC advance without IF/ID load
module fetch_pipe_front
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        regIF_en,
  input  logic        regID_en,
  input  logic        nopMux,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction_ID,
  output logic [31:0] pc_plus4_ID,
  output logic        valid_ID,
  output logic [31:0] instruction_EX,
  output logic        valid_EX,
  output logic [1:0]  fe_state,
  output logic [7:0]  stall_count,
  output logic        protocol_err
);

  localparam logic [64:0] IF_ID_EMPTY = {NOP, 32'd0, 1'b0};
  localparam logic [32:0] ID_EX_EMPTY = {NOP, 1'b0};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        if_advance;
  logic        bad_enables;
  logic [64:0] if_id_q;
  logic [32:0] id_ex_q;
  fe_state_t   state;
  fe_state_t   state_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Advancing the PC while IF/ID holds would drop the fetched word, so the
  // PC only moves when IF/ID also loads.
  assign if_advance  = regIF_en & regID_en;
  assign bad_enables = ~redirect & regIF_en & ~regID_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= 32'd0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (if_advance) begin
      pc <= pc_plus4;
    end
  end

  pipe_reg #(
    .WIDTH    (65),
    .RESET_VAL(IF_ID_EMPTY),
    .CLEAR_VAL(IF_ID_EMPTY)
  ) u_if_id (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (regID_en),
    .clear  (redirect),
    .d      ({imem_data, pc_plus4, 1'b1}),
    .q      (if_id_q)
  );

  assign instruction_ID = if_id_q[64:33];
  assign pc_plus4_ID    = if_id_q[32:1];
  assign valid_ID       = if_id_q[0];

  // ID/EX loads every cycle; a bubble or a flush is expressed as a clear.
  pipe_reg #(
    .WIDTH    (33),
    .RESET_VAL(ID_EX_EMPTY),
    .CLEAR_VAL(ID_EX_EMPTY)
  ) u_id_ex (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (1'b1),
    .clear  (redirect | nopMux),
    .d      ({instruction_ID, valid_ID}),
    .q      (id_ex_q)
  );

  assign instruction_EX = id_ex_q[32:1];
  assign valid_EX       = id_ex_q[0];

  // Stalled-cycle counter saturates rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= 8'd0;
    end else if (!redirect && !regID_en && stall_count != 8'hFF) begin
      stall_count <= stall_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_err <= 1'b0;
    end else if (bad_enables) begin
      protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FE_FILL;
    end else begin
      state <= state_next;
    end
  end

  // FILL is only reachable through reset; every edge re-evaluates the state.
  always_comb begin
    state_next = FE_RUN;
    if (redirect) begin
      state_next = FE_FLUSH;
    end else if (!regID_en) begin
      state_next = FE_STALL;
    end
  end

  assign fe_state = state;

endmodule

// File: doc/fetch_pipe_front.md
FETCH_PIPE_FRONT -- requirements
Module: fetch_pipe_front

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL expose ports, in this order:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- regIF_en  input  1  1 = PC may advance; 0 = hold PC
- regID_en  input  1  1 = IF/ID register loads; 0 = hold IF/ID
- nopMux  input  1  1 = inject bubble into ID/EX this cycle
- redirect  input  1  branch/jump taken, resolved in EX
- redirect_pc  input  32  target PC for redirect
- imem_data  input  32  instruction at imem_addr, same cycle
- imem_addr  output  32  current PC
- instruction_ID  output  32  IF/ID instruction
- pc_plus4_ID  output  32  IF/ID PC+4
- valid_ID  output  1  IF/ID holds a real instruction
- instruction_EX  output  32  ID/EX instruction
- valid_EX  output  1  ID/EX holds a real instruction
- fe_state  output  2  front-end state
- stall_count  output  8  saturating stalled-cycle count
- protocol_err  output  1  sticky illegal-enable flag

Function
REQ-003 SHALL drive imem_addr combinationally from the PC register.
REQ-004 SHALL define NOP as 32'h0000_0000 (sll $0,$0,0).
REQ-005 SHALL apply, per rising edge, priority redirect > stall > advance.
REQ-006 On redirect=1: PC <= redirect_pc; IF/ID <= NOP, valid_ID <= 0; ID/EX <= NOP, valid_EX <= 0; regIF_en, regID_en, nopMux ignored that cycle.
REQ-007 Without redirect, regIF_en=1: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-008 Without redirect, regIF_en=0: PC holds.
REQ-009 Without redirect, regID_en=1: instruction_ID <= imem_data, pc_plus4_ID <= PC+4, valid_ID <= 1; regID_en=0: IF/ID holds.
REQ-010 Without redirect, nopMux=1: instruction_EX <= NOP, valid_EX <= 0; nopMux=0: instruction_EX <= instruction_ID, valid_EX <= valid_ID.
REQ-011 regIF_en=1 with regID_en=0 (would lose a fetched instruction) SHALL be treated as regIF_en=0 and SHALL set protocol_err, which stays 1 until reset.
REQ-012 stall_count SHALL increment by 1 each edge with redirect=0 and regID_en=0, saturating at 8'hFF.
REQ-013 fe_state encodings: RUN=0, STALL=1, FLUSH=2, FILL=3.
REQ-014 Transitions per edge: redirect -> FLUSH; else regID_en=0 -> STALL; else -> RUN; FILL only entered by reset.
REQ-015 FILL and FLUSH SHALL last exactly one cycle unless redirect or stall recurs.
REQ-016 Latency: instruction at PC reaches instruction_ID one edge after fetch, instruction_EX one edge later, with no stall.

Reset
REQ-017 reset_n=0 SHALL immediately force: PC=0, instruction_ID=NOP, pc_plus4_ID=0, valid_ID=0, instruction_EX=NOP, valid_EX=0, fe_state=FILL, stall_count=0, protocol_err=0.
REQ-018 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; first edge after release fetches address 0.

Structure
REQ-019 NOP encoding, fe_state encodings and opcode constants SHALL live in shared package cpu_defs.
REQ-020 A single sub-module pipe_reg (parameterised width, load enable, synchronous clear-to-value, async active-low reset) SHALL implement IF/ID and ID/EX registers.

Verification
REQ-021 Reset release, enables 1, imem returns 32'h2008_0005 at 0 -> edge1 instruction_ID=32'h2008_0005, pc_plus4_ID=4, imem_addr=4; edge2 instruction_EX=32'h2008_0005, valid_EX=1.
REQ-022 regIF_en=regID_en=0, nopMux=1 for 2 cycles -> PC and IF/ID held, valid_EX=0 both cycles, stall_count=2, fe_state=STALL.
REQ-023 redirect=1, redirect_pc=32'h0000_0040, concurrent stall -> next edge imem_addr=32'h40, valid_ID=0, valid_EX=0, fe_state=FLUSH, stall_count unchanged.
REQ-024 PC forced via redirect to 32'hFFFF_FFFC, then advance -> imem_addr=0, pc_plus4_ID=0.
REQ-025 regIF_en=1, regID_en=0 -> PC held, protocol_err=1 and still 1 after 10 normal cycles; reset clears it.
REQ-026 300 consecutive stall cycles -> stall_count=8'hFF; reset_n pulsed mid-stall -> all REQ-017 values immediately.
